// File: rtl/testeram_mul_pkg.sv
// Shared definitions for the testeram multiply controller: FSM states,
// RAM word map, status-word bit positions and byte-enable patterns.
package testeram_mul_pkg;

  typedef enum logic [3:0] {
    INIT, IDLE, POLL, PWAIT, CHECK, ACK, RDA, AWAIT, RDB, BWAIT, MUL, WRP, WRS
  } state_t;

  // Word addresses inside the 4x32 testeram
  localparam logic [1:0] ADDR_A  = 2'd0;
  localparam logic [1:0] ADDR_B  = 2'd1;
  localparam logic [1:0] ADDR_P  = 2'd2;
  localparam logic [1:0] ADDR_CS = 2'd3;

  // Bit positions inside the command/status word
  localparam int START_BIT = 0;
  localparam int BUSY_BIT  = 8;
  localparam int DONE_BIT  = 9;
  localparam int OVF_BIT   = 10;
  localparam int CNT_LSB   = 16;

  // Byte lanes touched by each controller write of the status word
  localparam logic [3:0] ACK_BE  = 4'b0011;
  localparam logic [3:0] WRS_BE  = 4'b1110;
  localparam logic [3:0] INIT_BE = 4'b0010;

  // Build a status word; the start bit (byte 0) is always left at 0
  function automatic logic [31:0] status_word(input logic [15:0] cnt,
                                              input logic busy,
                                              input logic done,
                                              input logic ovf);
    logic [31:0] w;
    w = '0;
    w[BUSY_BIT] = busy;
    w[DONE_BIT] = done;
    w[OVF_BIT] = ovf;
    w[CNT_LSB +: 16] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/shift_add_mul32.sv
// 32x32 unsigned sequential shift-add multiplier, one iteration per cycle.
// start loads the operands; the next 32 cycles each perform one iteration.
// done is high during the cycle of the final iteration, and p presents the
// accumulator value after this cycle's iteration, so while done is high p
// already holds the complete 64-bit product.
module shift_add_mul32 (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [63:0] p
);

  logic [63:0] acc_reg;
  logic [63:0] mcand_reg;
  logic [31:0] mplr_reg;
  logic [4:0]  iter_reg;
  logic [63:0] acc_next;

  // Conditional add of the shifted multiplicand for the current iteration
  always_comb begin
    acc_next = acc_reg;
    if (mplr_reg[0]) acc_next = acc_reg + mcand_reg;
  end

  assign done = busy && (iter_reg == 5'd31);
  assign p    = acc_next;

  // Operand load on start, then 32 shift-add iterations
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_reg   <= '0;
      mcand_reg <= '0;
      mplr_reg  <= '0;
      iter_reg  <= '0;
      busy      <= 1'b0;
    end else if (start) begin
      acc_reg   <= '0;
      mcand_reg <= {32'd0, a};
      mplr_reg  <= b;
      iter_reg  <= '0;
      busy      <= 1'b1;
    end else if (busy) begin
      acc_reg   <= acc_next;
      mcand_reg <= mcand_reg << 1;
      mplr_reg  <= mplr_reg >> 1;
      iter_reg  <= iter_reg + 5'd1;
      if (iter_reg == 5'd31) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/testeram_mul_ctrl.sv
// Controller on port s2 of testeram: polls the command word, fetches A and B,
// multiplies them and posts the low product word and the status word.
// Bus outputs are registered so they appear in the same cycle the FSM is in
// the state that issues them (e.g. the ACK write is on the bus in ACK).
module testeram_mul_ctrl
  import testeram_mul_pkg::*;
#(
  parameter int RD_LAT      = 1,
  parameter int POLL_CYCLES = 16
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  output logic [1:0]  ram_address,
  output logic        ram_chipselect,
  output logic        ram_clken,
  output logic        ram_write,
  output logic [31:0] ram_writedata,
  output logic [3:0]  ram_byteenable,
  input  logic [31:0] ram_readdata,
  output logic        busy,
  output logic        done_pulse,
  output logic [15:0] job_count
);

  state_t      state_reg;
  logic [15:0] poll_cnt_reg;
  logic [1:0]  wait_cnt_reg;
  logic        start_seen_reg;
  logic [31:0] a_reg;
  logic        ovf_reg;

  logic        mul_start;
  logic        mul_busy;
  logic        mul_done;
  logic [63:0] mul_p;

  assign ram_clken = 1'b1;

  // B is handed to the multiplier straight from the read port on the
  // capture cycle, so the first iteration falls in the first MUL cycle
  assign mul_start = (state_reg == BWAIT) && (wait_cnt_reg == 2'd0);

  shift_add_mul32 u_mul (
    .clk   (clk_clk),
    .reset (reset_reset),
    .start (mul_start),
    .a     (a_reg),
    .b     (ram_readdata),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Job sequencer; each transition also loads the bus command of the next state
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_reg      <= INIT;
      poll_cnt_reg   <= '0;
      wait_cnt_reg   <= '0;
      start_seen_reg <= 1'b0;
      a_reg          <= '0;
      ovf_reg        <= 1'b0;
      ram_address    <= '0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_writedata  <= '0;
      ram_byteenable <= 4'hF;
      busy           <= 1'b0;
      done_pulse     <= 1'b0;
      job_count      <= '0;
    end else begin
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_byteenable <= 4'hF;
      done_pulse     <= 1'b0;
      unique case (state_reg)
        INIT: begin
          // Clear busy/done/ovf possibly left behind by an abandoned job
          ram_chipselect <= 1'b1;
          ram_write      <= 1'b1;
          ram_address    <= ADDR_CS;
          ram_byteenable <= INIT_BE;
          ram_writedata  <= '0;
          poll_cnt_reg   <= 16'(POLL_CYCLES - 1);
          state_reg      <= IDLE;
        end
        IDLE: begin
          if (poll_cnt_reg == 16'd0) begin
            ram_chipselect <= 1'b1;
            ram_address    <= ADDR_CS;
            state_reg      <= POLL;
          end else begin
            poll_cnt_reg <= poll_cnt_reg - 16'd1;
          end
        end
        POLL: begin
          wait_cnt_reg <= 2'(RD_LAT - 1);
          state_reg    <= PWAIT;
        end
        PWAIT: begin
          if (wait_cnt_reg == 2'd0) begin
            start_seen_reg <= ram_readdata[START_BIT];
            state_reg      <= CHECK;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        CHECK: begin
          if (start_seen_reg && enable) begin
            ram_chipselect <= 1'b1;
            ram_write      <= 1'b1;
            ram_address    <= ADDR_CS;
            ram_byteenable <= ACK_BE;
            ram_writedata  <= status_word(16'd0, 1'b1, 1'b0, 1'b0);
            busy           <= 1'b1;
            state_reg      <= ACK;
          end else begin
            poll_cnt_reg <= 16'(POLL_CYCLES - 1);
            state_reg    <= IDLE;
          end
        end
        ACK: begin
          ram_chipselect <= 1'b1;
          ram_address    <= ADDR_A;
          state_reg      <= RDA;
        end
        RDA: begin
          wait_cnt_reg <= 2'(RD_LAT - 1);
          state_reg    <= AWAIT;
        end
        AWAIT: begin
          if (wait_cnt_reg == 2'd0) begin
            a_reg          <= ram_readdata;
            ram_chipselect <= 1'b1;
            ram_address    <= ADDR_B;
            state_reg      <= RDB;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        RDB: begin
          wait_cnt_reg <= 2'(RD_LAT - 1);
          state_reg    <= BWAIT;
        end
        BWAIT: begin
          if (wait_cnt_reg == 2'd0) begin
            state_reg <= MUL;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 2'd1;
          end
        end
        MUL: begin
          if (mul_busy && mul_done) begin
            ram_chipselect <= 1'b1;
            ram_write      <= 1'b1;
            ram_address    <= ADDR_P;
            ram_byteenable <= 4'hF;
            ram_writedata  <= mul_p[31:0];
            ovf_reg        <= (mul_p[63:32] != 32'd0);
            state_reg      <= WRP;
          end
        end
        WRP: begin
          job_count      <= job_count + 16'd1;
          ram_chipselect <= 1'b1;
          ram_write      <= 1'b1;
          ram_address    <= ADDR_CS;
          ram_byteenable <= WRS_BE;
          ram_writedata  <= status_word(job_count + 16'd1, 1'b0, 1'b1, ovf_reg);
          done_pulse     <= 1'b1;
          state_reg      <= WRS;
        end
        WRS: begin
          busy         <= 1'b0;
          poll_cnt_reg <= 16'(POLL_CYCLES - 1);
          state_reg    <= IDLE;
        end
        default: state_reg <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_testeram_mul_ctrl.sv
// Bench for testeram_mul_ctrl: two controllers (RD_LAT=1 and RD_LAT=2), each
// attached to its own dual-port RAM model whose s1 side is driven by the bench
// acting as the HPS.
module tb_testeram_mul_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst     [2];
  logic        enable   [2];
  logic [1:0]  addr     [2];
  logic        cs       [2];
  logic        clken    [2];
  logic        wr       [2];
  logic [31:0] wdata    [2];
  logic [3:0]  be       [2];
  logic [31:0] rdata    [2];
  logic        busy     [2];
  logic        done_p   [2];
  logic [15:0] jcnt     [2];

  logic [31:0] mem      [2][4];
  logic [31:0] rd1      [2];
  logic [31:0] rd2      [2];
  logic        hps_we   [2];
  logic [1:0]  hps_addr [2];
  logic [31:0] hps_wdata[2];
  logic [3:0]  hps_be   [2];

  int checks = 0;
  int failures = 0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    testeram_mul_ctrl #(.RD_LAT(gi + 1), .POLL_CYCLES(16)) dut (
      .clk_clk        (clk),
      .reset_reset    (srst[gi]),
      .enable         (enable[gi]),
      .ram_address    (addr[gi]),
      .ram_chipselect (cs[gi]),
      .ram_clken      (clken[gi]),
      .ram_write      (wr[gi]),
      .ram_writedata  (wdata[gi]),
      .ram_byteenable (be[gi]),
      .ram_readdata   (rdata[gi]),
      .busy           (busy[gi]),
      .done_pulse     (done_p[gi]),
      .job_count      (jcnt[gi])
    );
  end

  // RAM model: s1 = bench (HPS), s2 = controller; read data appears after 1 or 2 cycles
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++) begin
        if (hps_we[k] && hps_be[k][b]) mem[k][hps_addr[k]][8*b +: 8] <= hps_wdata[k][8*b +: 8];
        if (cs[k] && wr[k] && be[k][b]) mem[k][addr[k]][8*b +: 8] <= wdata[k][8*b +: 8];
      end
      if (cs[k] && !wr[k]) rd1[k] <= mem[k][addr[k]];
      rd2[k] <= rd1[k];
    end
  end
  assign rdata[0] = rd1[0];
  assign rdata[1] = rd2[1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic hps_wr(input int i, input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    hps_addr[i] = a;
    hps_wdata[i] = d;
    hps_be[i] = b;
    hps_we[i] = 1'b1;
    @(negedge clk);
    hps_we[i] = 1'b0;
  endtask

  task automatic start_job(input int i, input logic [31:0] a, input logic [31:0] b);
    hps_wr(i, 2'd0, a, 4'hF);
    hps_wr(i, 2'd1, b, 4'hF);
    hps_wr(i, 2'd3, 32'h1, 4'b0001);
  endtask

  task automatic wait_ack(input int i, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 2000 && !ok; k++) begin
      @(negedge clk);
      if (cs[i] && wr[i] && addr[i] == 2'd3 && be[i] == 4'b0011) ok = 1'b1;
    end
  endtask

  // Cycles from the ACK cycle to the done_pulse cycle, -1 on timeout
  task automatic wait_done(input int i, output int lat);
    lat = -1;
    for (int k = 1; k <= 300 && lat < 0; k++) begin
      @(negedge clk);
      if (done_p[i]) lat = k;
    end
  endtask

  task automatic run_job(input int i, output int lat);
    bit ok;
    wait_ack(i, ok);
    if (ok) wait_done(i, lat);
    else lat = -1;
  endtask

  task automatic check_reset_outs(input int i, input string tag);
    chk({tag, "_ctl"}, {cs[i], wr[i], addr[i], be[i], busy[i], done_p[i], clken[i]},
        {1'b0, 1'b0, 2'b00, 4'hF, 1'b0, 1'b0, 1'b1});
    chk({tag, "_wdata"}, wdata[i], 32'h0);
    chk({tag, "_jcnt"}, jcnt[i], 16'h0);
  endtask

  task automatic check_init_cmd(input int i, input string tag);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin
      @(negedge clk);
      if (cs[i]) seen = 1'b1;
    end
    chk(tag, {cs[i], wr[i], addr[i], be[i], wdata[i]}, {1'b1, 1'b1, 2'd3, 4'b0010, 32'h0});
  endtask

  initial begin
    int lat, lat1;
    bit ok;
    int polls, bad, last, min_gap;
    for (int k = 0; k < 2; k++) begin
      srst[k] = 1'b1;
      enable[k] = 1'b1;
      hps_we[k] = 1'b0;
      hps_addr[k] = 2'd0;
      hps_wdata[k] = 32'h0;
      hps_be[k] = 4'h0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      hps_wr(k, 2'd0, 32'h0, 4'hF);
      hps_wr(k, 2'd1, 32'h0, 4'hF);
      hps_wr(k, 2'd2, 32'hDEAD_BEEF, 4'hF);
      hps_wr(k, 2'd3, 32'h0, 4'hF);
    end
    check_reset_outs(0, "reset");
    srst[0] = 1'b0;
    srst[1] = 1'b0;
    check_init_cmd(0, "init_cmd");

    // Basic product
    start_job(0, 32'd7, 32'd6);
    run_job(0, lat);
    chk("basic_lat", lat, 38);
    chk("basic_p", mem[0][2], 32'd42);
    @(negedge clk);
    chk("basic_st", mem[0][3], 32'h0001_0200);
    chk("basic_cnt", jcnt[0], 16'd1);

    // Overflow
    start_job(0, 32'h0001_0000, 32'h0001_0000);
    run_job(0, lat);
    chk("ovf_p", mem[0][2], 32'h0);
    @(negedge clk);
    chk("ovf_st", mem[0][3], 32'h0002_0600);

    // Large operands
    start_job(0, 32'hFFFF_FFFF, 32'd1);
    run_job(0, lat);
    chk("big1_p", mem[0][2], 32'hFFFF_FFFF);
    @(negedge clk);
    chk("big1_st", mem[0][3], 32'h0003_0200);
    start_job(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_job(0, lat);
    chk("big2_lat", lat, 38);
    chk("big2_p", mem[0][2], 32'h0000_0001);
    @(negedge clk);
    chk("big2_st", mem[0][3], 32'h0004_0600);

    // Enable gating
    enable[0] = 1'b0;
    start_job(0, 32'd2, 32'd9);
    polls = 0; bad = 0; last = -1000; min_gap = 1000000;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (cs[0]) begin
        if (wr[0] || addr[0] != 2'd3) bad++;
        else begin
          if (t - last < min_gap) min_gap = t - last;
          last = t;
          polls++;
        end
      end
    end
    chk("gate_bad_cmds", bad, 0);
    chk("gate_polled", polls > 0, 1);
    chk("gate_gap_ge16", min_gap >= 16, 1);
    enable[0] = 1'b1;
    run_job(0, lat);
    chk("gate_p", mem[0][2], 32'd18);
    @(negedge clk);
    chk("gate_st", mem[0][3], 32'h0005_0200);

    // Reset during MUL
    start_job(0, 32'd5, 32'd5);
    wait_ack(0, ok);
    chk("mid_ack", ok, 1);
    repeat (10) @(negedge clk);
    chk("mid_busy", busy[0], 1);
    srst[0] = 1'b1;
    @(negedge clk);
    check_reset_outs(0, "midrst");
    srst[0] = 1'b0;
    check_init_cmd(0, "re_init");
    repeat (3) @(negedge clk);
    chk("midrst_p", mem[0][2], 32'd18);
    chk("midrst_st", mem[0][3], 32'h0005_0000);

    // Back-to-back jobs, new start posted during MUL of the first
    for (int i = 0; i < 2; i++) begin
      start_job(i, 32'd4, 32'd11);
      wait_ack(i, ok);
      fork
        wait_done(i, lat1);
        begin
          repeat (10) @(negedge clk);
          start_job(i, 32'd3, 32'd5);
        end
      join
      chk($sformatf("b2b%0d_lat1", i), lat1, 38 + 2 * i);
      chk($sformatf("b2b%0d_p1", i), mem[i][2], 32'd44);
      chk($sformatf("b2b%0d_cnt1", i), jcnt[i], 16'd1);
      run_job(i, lat);
      chk($sformatf("b2b%0d_lat2", i), lat, 38 + 2 * i);
      chk($sformatf("b2b%0d_p2", i), mem[i][2], 32'd15);
      @(negedge clk);
      chk($sformatf("b2b%0d_st2", i), mem[i][3], 32'h0002_0200);
      chk($sformatf("b2b%0d_cnt2", i), jcnt[i], 16'd2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
